// File: rtl/opb_status_bank_ppc_if.sv
// opb_status_bank_ppc_if: OPB bus bundle between a master and opb_status_bank_ppc.
// OPB numbering is kept: bit 0 of every vector is its MSB.
interface opb_status_bank_ppc_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [0:AW-1]   OPB_ABus;
   logic [0:DW/8-1] OPB_BE;
   logic [0:DW-1]   OPB_DBus;
   logic            OPB_RNW;
   logic            OPB_select;
   logic            OPB_seqAddr;
   logic [0:DW-1]   Sl_DBus;
   logic            Sl_errAck;
   logic            Sl_retry;
   logic            Sl_toutSup;
   logic            Sl_xferAck;

   modport master (
      output OPB_ABus, OPB_BE, OPB_DBus,
      output OPB_RNW, OPB_select, OPB_seqAddr,
      input  Sl_DBus, Sl_errAck, Sl_retry,
      input  Sl_toutSup, Sl_xferAck
   );

   modport slave (
      input  OPB_ABus, OPB_BE, OPB_DBus,
      input  OPB_RNW, OPB_select, OPB_seqAddr,
      output Sl_DBus, Sl_errAck, Sl_retry,
      output Sl_toutSup, Sl_xferAck
   );
endinterface

// File: rtl/opb_status_bank_ppc.sv
// opb_status_bank_ppc: OPB slave with C_NUM_CH captured, sticky/W1C status words.
// Define OPB_STATUS_UPDCNT_EN to add 16-bit per-channel capture counters.
module opb_status_bank_ppc #(
   parameter logic [31:0] C_BASEADDR    = 32'h010C0100,
   parameter logic [31:0] C_HIGHADDR    = 32'h010C01FF,
   parameter int          C_OPB_AWIDTH  = 32,
   parameter int          C_OPB_DWIDTH  = 32,
   parameter int          C_NUM_CH      = 4,
   parameter int          C_DATA_W      = 32,
   parameter logic [31:0] C_STICKY_MASK = 32'h0
) (
   input  logic                         OPB_Clk,
   input  logic                         OPB_Rst,
   opb_status_bank_ppc_if.slave         opb,
   input  logic [C_NUM_CH*C_DATA_W-1:0] user_data_in,
   input  logic [C_NUM_CH-1:0]          user_valid,
   output logic                         irq
);
   localparam int AW = C_OPB_AWIDTH;
   localparam int DW = C_OPB_DWIDTH;
   localparam int BW = DW / 8;
   localparam logic [C_DATA_W-1:0] STK =
      C_STICKY_MASK[C_DATA_W-1:0];

   typedef enum logic [1:0] {
      IDLE, DECODE, ACK, HOLD
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, off;
   logic [DW-1:0] wdata_q, wmask, wbits;
   logic [0:BW-1] be_q;
   logic          rnw_q, latch, hit, wr;
   logic          tout_q, tout_d, ack_q, ack_d;
   logic [DW-1:0] dbus_q, dbus_d, rdata;
   logic          freeze_q, freeze_d;
   logic          irq_en_q, irq_en_d;
   logic [C_NUM_CH-1:0] pend_q, pend_d, rise, pclr, cap;
   logic [C_DATA_W-1:0] ch_q [C_NUM_CH];
   logic [C_DATA_W-1:0] ch_d [C_NUM_CH];
`ifdef OPB_STATUS_UPDCNT_EN
   logic [15:0] cnt_q [C_NUM_CH];
   logic [15:0] cnt_d [C_NUM_CH];
`endif

   assign hit = opb.OPB_select
             && opb.OPB_ABus >= C_BASEADDR
             && opb.OPB_ABus <= C_HIGHADDR;
   assign off = (addr_q - C_BASEADDR) >> 2;
   assign wr  = (state_q == ACK) && !rnw_q;

   // OPB_BE[0] covers the most significant byte lane
   always_comb begin
      wmask = '0;
      for (int j = 0; j < BW; j++)
         wmask[8*j +: 8] = {8{be_q[BW-1-j]}};
   end
   assign wbits = wdata_q & wmask;

   for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
      logic [C_DATA_W-1:0] dat, set, clr, keep;
      assign cap[i] = user_valid[i] & ~freeze_q;
      assign dat  = user_data_in[i*C_DATA_W +: C_DATA_W];
      assign set  = cap[i] ? (dat & STK) : '0;
      assign clr  = (wr && off == AW'(i)) ?
                    (wbits[C_DATA_W-1:0] & STK) : '0;
      assign keep = cap[i] ? (dat & ~STK) : (ch_q[i] & ~STK);
      assign ch_d[i] = keep | (ch_q[i] & STK & ~clr) | set;
      assign rise[i] = |(set & ~ch_q[i]);
`ifdef OPB_STATUS_UPDCNT_EN
      logic cwr;
      assign cwr = wr && off == AW'(C_NUM_CH + 2 + i);
      assign cnt_d[i] = cwr ? {15'd0, cap[i]} :
                        (cap[i] && cnt_q[i] != 16'hFFFF) ?
                        cnt_q[i] + 16'd1 : cnt_q[i];
`endif
   end

   assign pclr = (wr && off == AW'(C_NUM_CH + 1)) ?
                 wbits[C_NUM_CH-1:0] : '0;
   assign pend_d = (pend_q & ~pclr) | rise;

   always_comb begin
      freeze_d = freeze_q;
      irq_en_d = irq_en_q;
      if (wr && off == AW'(C_NUM_CH) && be_q[BW-1]) begin
         freeze_d = wdata_q[0];
         irq_en_d = wdata_q[1];
      end
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < C_NUM_CH; i++) begin
         if (off == AW'(i))
            rdata[C_DATA_W-1:0] = ch_q[i];
`ifdef OPB_STATUS_UPDCNT_EN
         if (off == AW'(C_NUM_CH + 2 + i))
            rdata[15:0] = cnt_q[i];
`endif
      end
      if (off == AW'(C_NUM_CH))
         rdata[1:0] = {irq_en_q, freeze_q};
      if (off == AW'(C_NUM_CH + 1))
         rdata[C_NUM_CH-1:0] = pend_q;
   end

   always_comb begin
      state_d = state_q;
      tout_d  = 1'b0;
      ack_d   = 1'b0;
      dbus_d  = '0;
      latch   = 1'b0;
      unique case (state_q)
         IDLE: if (hit) begin
            state_d = DECODE;
            tout_d  = 1'b1;
            latch   = 1'b1;
         end
         DECODE: begin
            state_d = ACK;
            ack_d   = 1'b1;
            if (rnw_q) dbus_d = rdata;
         end
         ACK:  state_d = HOLD;
         HOLD: if (!opb.OPB_select) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
      if (OPB_Rst) begin
         state_q  <= IDLE;
         tout_q   <= 1'b0;
         ack_q    <= 1'b0;
         dbus_q   <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         rnw_q    <= 1'b0;
         freeze_q <= 1'b0;
         irq_en_q <= 1'b0;
         pend_q   <= '0;
         irq      <= 1'b0;
         for (int i = 0; i < C_NUM_CH; i++)
            ch_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         tout_q   <= tout_d;
         ack_q    <= ack_d;
         dbus_q   <= dbus_d;
         if (latch) begin
            addr_q  <= opb.OPB_ABus;
            wdata_q <= opb.OPB_DBus;
            be_q    <= opb.OPB_BE;
            rnw_q   <= opb.OPB_RNW;
         end
         freeze_q <= freeze_d;
         irq_en_q <= irq_en_d;
         pend_q   <= pend_d;
         irq      <= irq_en_q & |pend_q;
         for (int i = 0; i < C_NUM_CH; i++)
            ch_q[i] <= ch_d[i];
      end
   end

`ifdef OPB_STATUS_UPDCNT_EN
   always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
      if (OPB_Rst) begin
         for (int i = 0; i < C_NUM_CH; i++)
            cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < C_NUM_CH; i++)
            cnt_q[i] <= cnt_d[i];
      end
   end
`endif

   assign opb.Sl_DBus    = dbus_q;
   assign opb.Sl_errAck  = 1'b0;
   assign opb.Sl_retry   = 1'b0;
   assign opb.Sl_toutSup = tout_q;
   assign opb.Sl_xferAck = ack_q;

   logic unused_ok;
   assign unused_ok = ^{opb.OPB_seqAddr, wdata_q, wmask, wbits};
endmodule

// File: doc/opb_status_bank_ppc.md
Name: opb_status_bank_ppc

Overview:
- Parametrised OPB slave exposing C_NUM_CH user status words to the PPC. Successor to the single-word simulink-to-PPC status register.
- Adds per-channel capture strobes, sticky write-1-to-clear bits, a global freeze, a pending/interrupt path and a registered two-cycle bus handshake.
- Sits on the OPB next to the other opb_register_* slaves. User logic is synchronous to OPB_Clk.

Parameters:
- C_BASEADDR, 32'h010C0100: first byte address of window
- C_HIGHADDR, 32'h010C01FF: last byte address of window
- C_OPB_AWIDTH, 32: OPB address width
- C_OPB_DWIDTH, 32: OPB data width
- C_NUM_CH, 4: number of status channels, 1..16
- C_DATA_W, 32: bits per channel, 1..32
- C_STICKY_MASK, 32'h0: channel bits that are sticky-set and W1C; same mask for all channels

Ports:
- OPB_Clk  in  1  sole clock
- OPB_Rst  in  1  asynchronous, active-high reset
- OPB_ABus  in  [0:31]  address
- OPB_BE  in  [0:3]  byte enables
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1=read
- OPB_select  in  1  transaction select
- OPB_seqAddr  in  1  ignored
- Sl_DBus  out  [0:31]  read data
- Sl_errAck  out  1  constant 0
- Sl_retry  out  1  constant 0
- Sl_toutSup  out  1  timeout suppress
- Sl_xferAck  out  1  transfer acknowledge
- user_data_in  in  C_NUM_CH*C_DATA_W  channel i at bits [i*C_DATA_W +: C_DATA_W]
- user_valid  in  C_NUM_CH  capture strobe per channel
- irq  out  1  registered interrupt

Behaviour:
- Reset: all channel registers, control, pending, irq, Sl_DBus, Sl_xferAck and Sl_toutSup = 0. FSM returns to IDLE. A transaction in flight when reset asserts is dropped with no ack.
- Hit: OPB_select=1 and C_BASEADDR<=OPB_ABus<=C_HIGHADDR. Word offset = (OPB_ABus-C_BASEADDR)>>2.
- Register map:
  - Offset 0..C_NUM_CH-1: channel registers.
  - Offset C_NUM_CH: control. Bit0 = freeze, bit1 = irq_en.
  - Offset C_NUM_CH+1: pending[C_NUM_CH-1:0], W1C.
  - Other offsets: read 0, writes ignored, still acked.
- Bit order: OPB bit 0 is MSB. Data is right-justified (Sl_DBus[31-k] = reg[k]). Unused upper bits read 0.
- FSM:
  - IDLE -> DECODE on hit; address, data, RNW and BE are registered.
  - DECODE -> ACK.
  - ACK -> HOLD.
  - HOLD -> IDLE when OPB_select=0.
- Latency: select sampled at edge 0; Sl_toutSup=1 during DECODE; Sl_xferAck=1 for exactly one cycle in ACK.
- Sl_DBus carries read data only in ACK and is 0 otherwise (OR-bus). Write side effects commit at the ACK cycle.
- Writes honour OPB_BE per byte. Control and pending writes are byte-masked the same way.
- Capture, per channel i, when user_valid[i]=1 and freeze=0:
  - Non-sticky bits <= data.
  - Sticky bits <= reg | data.
  - While freeze=1, strobes are ignored.
- Pending: pending[i] sets when any sticky bit of channel i goes 0->1.
- W1C:
  - Writing a channel clears sticky bits written 1. Non-sticky bits are read-only.
  - Writing pending clears the bits written 1.
- Simultaneous set and clear in one cycle: set wins for both sticky bits and pending.
- irq <= irq_en & |pending, registered (one cycle after pending changes).

Optional Feature:
- Macro OPB_STATUS_UPDCNT_EN.
- When defined: offsets C_NUM_CH+2+i hold a 16-bit per-channel capture counter.
  - Increments on each accepted capture (freeze=0).
  - Saturates at 16'hFFFF.
  - Any write clears it; if a capture occurs in the same cycle, the counter is set to 1.
- When undefined: those offsets read 0 and have no logic.

Test Plan:
All scenarios use C_NUM_CH=4, C_DATA_W=16, C_STICKY_MASK=32'h8000.
- Reset then read 0x010C0108 -> Sl_xferAck exactly one cycle, two cycles after select; data 0; Sl_errAck/Sl_retry stay 0.
- Pulse user_valid[2] with ch2 data 0x8123, then 0x0456 -> read ch2 = 0x8456; pending=0x4. Enable irq_en (write 0x2 to 0x010C0110) -> irq=1.
- Write 0x8000 to 0x010C0108, then write 0x4 to 0x010C0114 -> ch2 reads 0x0456; pending 0; irq low next cycle.
- Write 0x8000 to 0x010C0108 in the same cycle user_valid[2]=1 with data 0x8001 -> ch2 = 0x8001; sticky bit stays set.
- Set freeze (write 0x1 to 0x010C0110), pulse user_valid[0] with 0x1234 -> ch0 unchanged.
  - Read 0x010C0180 (out-of-map) -> acked, data 0.
  - Assert OPB_Rst during DECODE -> no ack; all outputs 0.
- With OPB_STATUS_UPDCNT_EN: 70000 pulses on user_valid[1] -> 0x010C011C reads 0xFFFF. Write it -> reads 0.
  - Without the macro, the same read returns 0.
